rs_encoder: RTL and testbench

- Systematic Reed-Solomon encoder over GF(2^M). It is the transmit-side counterpart of the GF-arithmetic decode path.
- Accepts K message symbols on a valid/ready stream and passes them through unchanged. It then appends N-K parity symbols computed by a generator-polynomial LFSR.
- One symbol per cycle when not backpressured. Output feeds the channel/packer; the decoder consumes it downstream.

---
 rtl/rs_pkg.sv | 44 ++++
 rtl/rs_encoder_gf_mul_const.sv | 27 ++
 rtl/rs_encoder.sv | 119 +++++++++++
 tb/tb_rs_encoder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared types and elaboration-time Galois-field helpers for the Reed-Solomon encoder.
package rs_pkg;

    localparam int RS_M         = 8;
    localparam int RS_PRIM_POLY = 'h11D;

    typedef enum logic {
        MSG    = 1'b0,
        PARITY = 1'b1
    } state_t;

    // Shift-and-xor multiply in GF(2^m); usable in constant expressions.
    function automatic int gf_mul(input int a, input int b,
                                  input int m = RS_M, input int poly = RS_PRIM_POLY);
        int acc;
        int x;
        acc = 0;
        x   = a;
        for (int i = 0; i < m; i++) begin
            if (((b >> i) & 1) != 0) acc = acc ^ x;
            x = x << 1;
            if (((x >> m) & 1) != 0) x = x ^ poly;
        end
        return acc;
    endfunction

    // Coefficient i of g(x) = prod_{j=0..n-k-1} (x + alpha^(fcr+j)), alpha = x.
    function automatic int gen_poly_coef(input int i, input int n, input int k,
                                         input int fcr, input int m, input int poly);
        int g [0:255];
        int root;
        for (int d = 0; d < 256; d++) g[d] = 0;
        g[0] = 1;
        root = 1;
        for (int e = 0; e < fcr; e++) root = gf_mul(root, 2, m, poly);
        for (int j = 0; j < n - k; j++) begin
            for (int d = j + 1; d > 0; d--) g[d] = g[d-1] ^ gf_mul(g[d], root, m, poly);
            g[0] = gf_mul(g[0], root, m, poly);
            root = gf_mul(root, 2, m, poly);
        end
        return g[i];
    endfunction

endpackage

// File: rtl/rs_encoder_gf_mul_const.sv
// Combinational multiply of an M-bit symbol by the constant C in GF(2^M).
// Latency 0; no handshake.
module gf_mul_const
    import rs_pkg::*;
#(
    parameter int M         = RS_M,
    parameter int C         = 1,
    parameter int PRIM_POLY = RS_PRIM_POLY
) (
    input  logic [M-1:0] a,
    output logic [M-1:0] y
);

    logic [M-1:0] terms [M];

    // Each input bit selects the precomputed product C * x^b.
    for (genvar b = 0; b < M; b++) begin : g_term
        localparam int CB = gf_mul(C, 1 << b, M, PRIM_POLY);
        assign terms[b] = a[b] ? M'(CB) : '0;
    end

    always_comb begin
        y = '0;
        for (int b = 0; b < M; b++) y = y ^ terms[b];
    end

endmodule

// File: rtl/rs_encoder.sv
// Systematic RS(N,K) encoder: passes K message symbols, then appends N-K LFSR parity symbols.
// Latency: 1 cycle from input accept (or parity load) to out_valid.
// Backpressure: single output register; nothing advances unless the slot is free, input stalls during parity.
module rs_encoder
    import rs_pkg::*;
#(
    parameter int M         = RS_M,
    parameter int N         = 255,
    parameter int K         = 223,
    parameter int PRIM_POLY = RS_PRIM_POLY,
    parameter int FCR       = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] out_data,
    output logic         out_last
);

    localparam int TT = N - K;
    localparam int CW = $clog2(((K > TT) ? K : TT) + 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [M-1:0]  par     [TT];
    logic [M-1:0]  par_nxt [TT];
    logic [M-1:0]  gfb     [TT];
    logic [M-1:0]  fb;
    logic          slot_free;
    logic          accept;
    logic          par_load;
    logic          msg_end;
    logic          par_end;

    assign slot_free = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign fb        = in_data ^ par[TT-1];
    assign msg_end   = (cnt == CW'(K - 1));
    assign par_end   = (cnt == CW'(TT - 1));

    for (genvar i = 0; i < TT; i++) begin : g_coef
        gf_mul_const #(
            .M         (M),
            .C         (gen_poly_coef(i, N, K, FCR, M, PRIM_POLY)),
            .PRIM_POLY (PRIM_POLY)
        ) u_mul (
            .a (fb),
            .y (gfb[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) state <= MSG;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MSG:     if (accept && msg_end)     state_nxt = PARITY;
            PARITY:  if (par_load && par_end)   state_nxt = MSG;
            default: state_nxt = MSG;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        par_load = 1'b0;
        case (state)
            MSG:     in_ready = slot_free;
            PARITY:  par_load = slot_free;
            default: ;
        endcase
    end

    // Message symbols divide through g(x); parity drains by shifting toward the top tap.
    always_comb begin
        for (int i = 0; i < TT; i++) par_nxt[i] = par[i];
        if (accept) begin
            par_nxt[0] = gfb[0];
            for (int i = 1; i < TT; i++) par_nxt[i] = par[i-1] ^ gfb[i];
        end else if (par_load) begin
            par_nxt[0] = '0;
            for (int i = 1; i < TT; i++) par_nxt[i] = par[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TT; i++) par[i] <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            for (int i = 0; i < TT; i++) par[i] <= par_nxt[i];
            if (accept) begin
                cnt       <= msg_end ? '0 : cnt + CW'(1);
                out_data  <= in_data;
                out_valid <= 1'b1;
                out_last  <= 1'b0;
            end else if (par_load) begin
                cnt       <= par_end ? '0 : cnt + CW'(1);
                out_data  <= par[TT-1];
                out_valid <= 1'b1;
                out_last  <= par_end;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rs_encoder.sv
// Directed/random bench for rs_encoder: RS(255,223) against a division-based model, plus an RS(15,11) vector.
module tb_rs_encoder;

    localparam int N8 = 255;
    localparam int K8 = 223;
    localparam int T8 = N8 - K8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid8 = 1'b0;
    logic       in_ready8;
    logic [7:0] in_data8 = '0;
    logic       out_valid8;
    logic       out_ready8 = 1'b1;
    logic [7:0] out_data8;
    logic       out_last8;

    logic       in_valid4 = 1'b0;
    logic       in_ready4;
    logic [3:0] in_data4 = '0;
    logic       out_valid4;
    logic       out_ready4 = 1'b1;
    logic [3:0] out_data4;
    logic       out_last4;

    always #5 clk = ~clk;

    rs_encoder u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_data   (in_data8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_data  (out_data8),
        .out_last  (out_last8)
    );

    rs_encoder #(.M(4), .N(15), .K(11), .PRIM_POLY('h13), .FCR(1)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_data   (in_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_data  (out_data4),
        .out_last  (out_last4)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int stalls   = 0;
    int stab_err = 0;
    bit bp_on    = 1'b0;

    int gexp [0:509];
    int glog [0:255];
    int gen  [0:T8];

    int   tx_q  [$];
    int   exp_q [$];
    logic [7:0] out_q  [$];
    logic       last_q [$];

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s[%0d]: observed %0h, expected %0h", tag, idx, obs, expv);
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gexp[glog[a] + glog[b]];
    endfunction

    // Log/antilog tables and g(x) (ascending coefficients) for GF(256), poly 0x11D, roots alpha^0..31.
    function automatic void build_field();
        int x;
        x = 1;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = x;
            gexp[i+255] = x;
            glog[x] = i;
            x = x << 1;
            if (x >= 256) x = x ^ 'h11D;
        end
        for (int i = 0; i <= T8; i++) gen[i] = 0;
        gen[0] = 1;
        for (int j = 0; j < T8; j++) begin
            for (int d = j + 1; d > 0; d--) gen[d] = gen[d-1] ^ gmul(gen[d], gexp[j]);
            gen[0] = gmul(gen[0], gexp[j]);
        end
    endfunction

    // Queue one message (zero or random) and its codeword by polynomial long division.
    function automatic void make_cw(input bit rnd);
        int msg [0:K8-1];
        int w   [0:N8-1];
        for (int i = 0; i < N8; i++) w[i] = 0;
        for (int i = 0; i < K8; i++) begin
            msg[i] = rnd ? int'($urandom_range(0, 255)) : 0;
            w[i] = msg[i];
        end
        for (int i = 0; i < K8; i++)
            if (w[i] != 0)
                for (int j = 1; j <= T8; j++) w[i+j] = w[i+j] ^ gmul(gen[T8-j], w[i]);
        for (int i = 0; i < K8; i++) begin
            tx_q.push_back(msg[i]);
            exp_q.push_back(msg[i]);
        end
        for (int i = K8; i < N8; i++) exp_q.push_back(w[i]);
    endfunction

    always @(negedge clk) out_ready8 = bp_on ? ($urandom_range(0, 99) >= 40) : 1'b1;

    // Output monitor: records transfers, flags any change while stalled.
    always begin : mon
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && !(out_valid8 && out_data8 == prev_data && out_last8 == prev_last))
                    stab_err++;
                if (out_valid8 && out_ready8) begin
                    out_q.push_back(out_data8);
                    last_q.push_back(out_last8);
                end
                prev_stall = out_valid8 && !out_ready8;
                prev_data  = out_data8;
                prev_last  = out_last8;
            end
        end
    end

    task automatic drive(input bit gappy);
        int  cyc;
        bit  held;
        cyc  = 0;
        held = 1'b0;
        while (tx_q.size() > 0 && cyc < 20000) begin
            @(negedge clk);
            if (!held) begin
                if (gappy && $urandom_range(0, 2) == 0) begin
                    in_valid8 = 1'b0;
                end else begin
                    in_valid8 = 1'b1;
                    in_data8  = 8'(tx_q[0]);
                end
            end
            #2;
            if (in_valid8 && in_ready8) begin
                void'(tx_q.pop_front());
                held = 1'b0;
            end else begin
                held = in_valid8;
                if (in_valid8) stalls++;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid8 = 1'b0;
        if (tx_q.size() != 0) begin
            chk("drive_timeout", 0, tx_q.size(), 0);
            finish_run();
        end
    endtask

    task automatic check_cw(input string tag, input bit syn);
        int         c;
        logic [7:0] rx [0:N8-1];
        int         acc;
        c = 0;
        while (out_q.size() < N8 && c < 8000) begin
            @(negedge clk);
            c++;
        end
        if (out_q.size() < N8) begin
            chk({tag, "_timeout"}, 0, out_q.size(), N8);
            finish_run();
        end
        for (int i = 0; i < N8; i++) begin
            rx[i] = out_q.pop_front();
            chk({tag, "_data"}, i, rx[i], exp_q.pop_front());
            chk({tag, "_last"}, i, last_q.pop_front(), (i == N8 - 1) ? 1 : 0);
        end
        if (syn) begin
            for (int j = 0; j < T8; j++) begin
                acc = 0;
                for (int i = 0; i < N8; i++) acc = gmul(acc, gexp[j]) ^ int'(rx[i]);
                chk({tag, "_syndrome"}, j, acc, 0);
            end
        end
    endtask

    initial begin : main
        int exp4 [0:14];
        int rx4  [$];
        int l4   [$];
        int sent;

        build_field();
        exp4 = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 13, 12, 8, 7};

        repeat (3) @(negedge clk);
        #2;
        chk("rst_out_valid8", 0, out_valid8, 0);
        chk("rst_out_last8",  0, out_last8,  0);
        chk("rst_out_data8",  0, out_data8,  0);
        chk("rst_in_ready8",  0, in_ready8,  1);
        chk("rst_out_valid4", 0, out_valid4, 0);
        chk("rst_out_data4",  0, out_data4,  0);
        @(negedge clk);
        rst = 1'b0;

        // RS(15,11), message with a single 1 in the last position.
        sent = 0;
        for (int i = 0; i < 40 && rx4.size() < 15; i++) begin
            @(negedge clk);
            if (sent < 11) begin
                in_valid4 = 1'b1;
                in_data4  = (sent == 10) ? 4'd1 : 4'd0;
            end else begin
                in_valid4 = 1'b0;
            end
            #2;
            if (in_valid4 && in_ready4) sent++;
            if (out_valid4) begin
                rx4.push_back(int'(out_data4));
                l4.push_back(int'(out_last4));
            end
        end
        in_valid4 = 1'b0;
        chk("rs15_count", 0, rx4.size(), 15);
        for (int i = 0; i < 15 && i < rx4.size(); i++) begin
            chk("rs15_data", i, rx4[i], exp4[i]);
            chk("rs15_last", i, l4[i], (i == 14) ? 1 : 0);
        end

        // All-zero RS(255,223) codeword.
        make_cw(1'b0);
        drive(1'b0);
        check_cw("zero", 1'b0);

        // Random messages: first half free-flowing, second half with gaps and backpressure.
        for (int n = 0; n < 50; n++) begin
            bp_on = (n >= 25);
            make_cw(1'b1);
            drive(n >= 25);
            check_cw(bp_on ? "rand_bp" : "rand", 1'b1);
            chk("no_extra_out", n, out_q.size(), 0);
        end
        bp_on = 1'b0;
        chk("stall_stable", 0, stab_err, 0);

        // Three codewords back to back: input stalls exactly 2T cycles at each boundary.
        repeat (2) @(negedge clk);
        stalls = 0;
        for (int n = 0; n < 3; n++) make_cw(1'b1);
        drive(1'b0);
        chk("b2b_stalls", 0, stalls, 2 * T8);
        for (int n = 0; n < 3; n++) check_cw("b2b", 1'b0);

        // Reset after 100 message symbols, then a zero message must give zero parity.
        for (int i = 0; i < 100; i++) tx_q.push_back(int'($urandom_range(1, 255)));
        drive(1'b0);
        rst = 1'b1;
        @(negedge clk);
        #2;
        chk("midrst_out_valid", 0, out_valid8, 0);
        chk("midrst_out_last",  0, out_last8,  0);
        chk("midrst_in_ready",  0, in_ready8,  1);
        out_q.delete();
        last_q.delete();
        @(negedge clk);
        rst = 1'b0;
        make_cw(1'b0);
        drive(1'b0);
        check_cw("post_rst", 1'b0);

        finish_run();
    end

endmodule
